// File: rtl/slave_i2c_pkg.sv
// Shared definitions for the I2C slave address receiver.
//   state_t        : address-phase FSM states
//   path_t         : which acknowledge path the first byte selected
//   TENBIT_PREFIX_DEF, GEN_CALL_ADDR, ACK/NACK levels
//   tenbit_hdr_hit : 10-bit header compare (prefix + own[9:8])
package slave_i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BYTE1,
    ST_ACK1,
    ST_BYTE2,
    ST_ACK2,
    ST_ADDRESSED,
    ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    PATH_7BIT,
    PATH_GCALL,
    PATH_10W,
    PATH_10R
  } path_t;

  localparam logic [4:0] TENBIT_PREFIX_DEF = 5'b11110;
  localparam logic [7:0] GEN_CALL_ADDR     = 8'h00;
  localparam logic       ACK               = 1'b0;
  localparam logic       NACK              = 1'b1;

  // True when a first byte carries the 10-bit header for our upper address bits.
  function automatic logic tenbit_hdr_hit(input logic [7:0] byte_in,
                                          input logic [4:0] prefix,
                                          input logic [1:0] own_hi);
    return (byte_in[7:3] == prefix) && (byte_in[2:1] == own_hi);
  endfunction

endpackage

// File: rtl/slave_sipo_shift8.sv
// 8-bit MSB-first serial-in/parallel-out shifter with bit counter.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of data, counter and full flag (wins over shift)
//   shift_en   : shift serial_in into the LSB
//   byte_out   : current shift register contents
//   byte_full  : set by the 8th shift, cleared by clr or the next shift
module slave_sipo_shift8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       serial_in,
  output logic [7:0] byte_out,
  output logic       byte_full
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q, full_d;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (clr) begin
      sr_d   = '0;
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (shift_en) begin
      sr_d   = {sr_q[6:0], serial_in};
      // Counter wraps to 0 after the 8th bit; full marks that wrap.
      cnt_d  = cnt_q + 3'd1;
      full_d = (cnt_q == 3'd7);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign byte_out  = sr_q;
  assign byte_full = full_q;

endmodule

// File: rtl/slave_addr_rx.sv
// I2C slave address receiver (7-bit / 10-bit, optional general call).
// Shifts in the address byte(s) after every (repeated) START, compares with
// slave_own_addr and drives the ACK slot. All state on slave_scl_sixt.
//   slave_scl_sixt, slave_rst       : clock, async active-high reset
//   slave_serial_in                 : synchronised SDA
//   slave_scl_rise/_fall            : SCL edge strobes
//   slave_start/_stop               : bus condition pulses
//   slave_own_addr[9:0]             : own address ([6:0] in 7-bit mode)
//   slave_addr_out[9:0]             : last acknowledged address
//   slave_rd_wr                     : R/W bit of the last first byte
//   slave_addr_match/_gen_call      : addressed / general-call levels
//   slave_addr_done                 : pulse when the address phase ends with ACK
//   slave_ack_drive                 : pull SDA low during the ACK slot
//   slave_busy                      : address phase in progress
module slave_addr_rx
  import slave_i2c_pkg::*;
#(
  parameter int unsigned ADDR_BITS     = 7,
  parameter bit          GC_EN         = 1'b1,
  parameter logic [4:0]  TENBIT_PREFIX = TENBIT_PREFIX_DEF
) (
  input  logic       slave_scl_sixt,
  input  logic       slave_rst,
  input  logic       slave_serial_in,
  input  logic       slave_scl_rise,
  input  logic       slave_scl_fall,
  input  logic       slave_start,
  input  logic       slave_stop,
  input  logic [9:0] slave_own_addr,
  output logic [9:0] slave_addr_out,
  output logic       slave_rd_wr,
  output logic       slave_addr_match,
  output logic       slave_gen_call,
  output logic       slave_addr_done,
  output logic       slave_ack_drive,
  output logic       slave_busy
);

  localparam bit TEN_BIT = (ADDR_BITS == 10);

  state_t     state_q, state_d;
  path_t      path_q, path_d;
  logic       tenbit_hit_q, tenbit_hit_d;
  logic [6:0] hdr_q, hdr_d;          // first byte [7:1]
  logic [7:0] low_q, low_d;          // last accepted 10-bit low byte
  logic [9:0] addr_out_q, addr_out_d;
  logic       rd_wr_q, rd_wr_d;
  logic       match_q, match_d;
  logic       gen_call_q, gen_call_d;
  logic       done_q, done_d;
  logic       ack_q, ack_d;

  logic       sh_clr, sh_en, sh_full;
  logic [7:0] sh_byte;
  logic       fall_ok;
  logic       hdr_hit;

  slave_sipo_shift8 u_shift (
    .clk       (slave_scl_sixt),
    .rst       (slave_rst),
    .clr       (sh_clr),
    .shift_en  (sh_en),
    .serial_in (slave_serial_in),
    .byte_out  (sh_byte),
    .byte_full (sh_full)
  );

  always_comb begin
    // Simultaneous rise and fall: the rise is taken, the fall dropped.
    fall_ok = slave_scl_fall && !slave_scl_rise;
    hdr_hit = tenbit_hdr_hit(sh_byte, TENBIT_PREFIX, slave_own_addr[9:8]);
    sh_en   = slave_scl_rise && !slave_start && !slave_stop &&
              ((state_q == ST_BYTE1) || (state_q == ST_BYTE2));

    state_d      = state_q;
    path_d       = path_q;
    tenbit_hit_d = tenbit_hit_q;
    hdr_d        = hdr_q;
    low_d        = low_q;
    addr_out_d   = addr_out_q;
    rd_wr_d      = rd_wr_q;
    match_d      = match_q;
    gen_call_d   = gen_call_q;
    done_d       = 1'b0;
    ack_d        = ack_q;
    sh_clr       = 1'b0;

    if (slave_start) begin
      state_d    = ST_BYTE1;
      sh_clr     = 1'b1;
      match_d    = 1'b0;
      gen_call_d = 1'b0;
      ack_d      = 1'b0;
    end else if (slave_stop) begin
      state_d      = ST_IDLE;
      sh_clr       = 1'b1;
      tenbit_hit_d = 1'b0;
      match_d      = 1'b0;
      gen_call_d   = 1'b0;
      ack_d        = 1'b0;
    end else if (fall_ok) begin
      unique case (state_q)
        ST_BYTE1: if (sh_full) begin
          rd_wr_d = sh_byte[0];
          hdr_d   = sh_byte[7:1];
          if (GC_EN && (sh_byte == GEN_CALL_ADDR)) begin
            ack_d   = 1'b1;
            path_d  = PATH_GCALL;
            state_d = ST_ACK1;
          end else if (!TEN_BIT && (sh_byte[7:1] == slave_own_addr[6:0])) begin
            ack_d   = 1'b1;
            path_d  = PATH_7BIT;
            state_d = ST_ACK1;
          end else if (TEN_BIT && hdr_hit && !sh_byte[0]) begin
            ack_d   = 1'b1;
            path_d  = PATH_10W;
            state_d = ST_ACK1;
          end else if (TEN_BIT && hdr_hit && sh_byte[0] && tenbit_hit_q) begin
            ack_d   = 1'b1;
            path_d  = PATH_10R;
            state_d = ST_ACK1;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_ACK1: begin
          ack_d = 1'b0;
          unique case (path_q)
            PATH_10W: begin
              state_d = ST_BYTE2;
              sh_clr  = 1'b1;
            end
            PATH_GCALL: begin
              state_d    = ST_ADDRESSED;
              done_d     = 1'b1;
              gen_call_d = 1'b1;
              addr_out_d = '0;
            end
            PATH_7BIT: begin
              state_d    = ST_ADDRESSED;
              done_d     = 1'b1;
              match_d    = 1'b1;
              addr_out_d = {3'b000, hdr_q};
            end
            PATH_10R: begin
              state_d    = ST_ADDRESSED;
              done_d     = 1'b1;
              match_d    = 1'b1;
              addr_out_d = {hdr_q[1:0], low_q};
            end
            default: state_d = ST_IGNORE;
          endcase
        end
        ST_BYTE2: if (sh_full) begin
          if (sh_byte == slave_own_addr[7:0]) begin
            ack_d        = 1'b1;
            tenbit_hit_d = 1'b1;
            low_d        = sh_byte;
            state_d      = ST_ACK2;
          end else begin
            tenbit_hit_d = 1'b0;
            state_d      = ST_IGNORE;
          end
        end
        ST_ACK2: begin
          ack_d      = 1'b0;
          state_d    = ST_ADDRESSED;
          done_d     = 1'b1;
          match_d    = 1'b1;
          addr_out_d = {hdr_q[1:0], low_q};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge slave_scl_sixt or posedge slave_rst) begin
    if (slave_rst) begin
      state_q      <= ST_IDLE;
      path_q       <= PATH_7BIT;
      tenbit_hit_q <= 1'b0;
      hdr_q        <= '0;
      low_q        <= '0;
      addr_out_q   <= '0;
      rd_wr_q      <= 1'b0;
      match_q      <= 1'b0;
      gen_call_q   <= 1'b0;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      path_q       <= path_d;
      tenbit_hit_q <= tenbit_hit_d;
      hdr_q        <= hdr_d;
      low_q        <= low_d;
      addr_out_q   <= addr_out_d;
      rd_wr_q      <= rd_wr_d;
      match_q      <= match_d;
      gen_call_q   <= gen_call_d;
      done_q       <= done_d;
      ack_q        <= ack_d;
    end
  end

  assign slave_addr_out   = addr_out_q;
  assign slave_rd_wr      = rd_wr_q;
  assign slave_addr_match = match_q;
  assign slave_gen_call   = gen_call_q;
  assign slave_addr_done  = done_q;
  assign slave_ack_drive  = ack_q;
  assign slave_busy       = (state_q == ST_BYTE1) || (state_q == ST_ACK1) ||
                            (state_q == ST_BYTE2) || (state_q == ST_ACK2);

endmodule

// File: tb/tb_slave_addr_rx.sv
// Bench for slave_addr_rx: three instances share one bus
//   dut0 7-bit GC on, dut1 10-bit GC on, dut2 7-bit GC off.
// A transaction-level model predicts ACKs and completed addresses; completed
// addresses go into per-instance queues popped by a monitor on slave_addr_done.
module tb_slave_addr_rx;

  logic clk = 1'b0;
  logic rst, sda, rise, fall, start, stop;
  logic [9:0] own [3];
  logic [9:0] addr_out [3];
  logic rd_wr [3], match [3], gcall [3], done [3], ack [3], busy [3];

  always #5 clk = ~clk;

  slave_addr_rx #(.ADDR_BITS(7), .GC_EN(1'b1)) u_dut0 (
    .slave_scl_sixt(clk), .slave_rst(rst), .slave_serial_in(sda),
    .slave_scl_rise(rise), .slave_scl_fall(fall), .slave_start(start), .slave_stop(stop),
    .slave_own_addr(own[0]), .slave_addr_out(addr_out[0]), .slave_rd_wr(rd_wr[0]),
    .slave_addr_match(match[0]), .slave_gen_call(gcall[0]), .slave_addr_done(done[0]),
    .slave_ack_drive(ack[0]), .slave_busy(busy[0]));

  slave_addr_rx #(.ADDR_BITS(10), .GC_EN(1'b1)) u_dut1 (
    .slave_scl_sixt(clk), .slave_rst(rst), .slave_serial_in(sda),
    .slave_scl_rise(rise), .slave_scl_fall(fall), .slave_start(start), .slave_stop(stop),
    .slave_own_addr(own[1]), .slave_addr_out(addr_out[1]), .slave_rd_wr(rd_wr[1]),
    .slave_addr_match(match[1]), .slave_gen_call(gcall[1]), .slave_addr_done(done[1]),
    .slave_ack_drive(ack[1]), .slave_busy(busy[1]));

  slave_addr_rx #(.ADDR_BITS(7), .GC_EN(1'b0)) u_dut2 (
    .slave_scl_sixt(clk), .slave_rst(rst), .slave_serial_in(sda),
    .slave_scl_rise(rise), .slave_scl_fall(fall), .slave_start(start), .slave_stop(stop),
    .slave_own_addr(own[2]), .slave_addr_out(addr_out[2]), .slave_rd_wr(rd_wr[2]),
    .slave_addr_match(match[2]), .slave_gen_call(gcall[2]), .slave_addr_done(done[2]),
    .slave_ack_drive(ack[2]), .slave_busy(busy[2]));

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [9:0] addr;
    logic       rw;
    logic       match;
    logic       gc;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  // Model state: phase 0 = not listening, 1 = expecting first byte, 2 = expecting low byte.
  int         m_phase [3];
  bit         m_hit   [3];
  logic [7:0] m_low   [3];
  logic [1:0] m_hi    [3];

  function automatic bit is10(input int i); return i == 1; endfunction
  function automatic bit gcen(input int i); return i != 2; endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, inst, act, req, $time);
    end
  endtask

  task automatic push_exp(input int i, input exp_t e);
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int i, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic model_byte(input int i, input logic [7:0] b, output bit ack_e);
    ack_e = 1'b0;
    if (m_phase[i] == 1) begin
      m_phase[i] = 0;
      if (gcen(i) && b == 8'h00) begin
        ack_e = 1'b1;
        push_exp(i, '{addr: 10'd0, rw: b[0], match: 1'b0, gc: 1'b1});
      end else if (!is10(i) && b[7:1] == own[i][6:0]) begin
        ack_e = 1'b1;
        push_exp(i, '{addr: {3'b000, b[7:1]}, rw: b[0], match: 1'b1, gc: 1'b0});
      end else if (is10(i) && b[7:3] == 5'b11110 && b[2:1] == own[i][9:8]) begin
        if (!b[0]) begin
          ack_e      = 1'b1;
          m_phase[i] = 2;
          m_hi[i]    = b[2:1];
        end else if (m_hit[i]) begin
          ack_e = 1'b1;
          push_exp(i, '{addr: {b[2:1], m_low[i]}, rw: 1'b1, match: 1'b1, gc: 1'b0});
        end
      end
    end else if (m_phase[i] == 2) begin
      m_phase[i] = 0;
      if (b == own[i][7:0]) begin
        ack_e    = 1'b1;
        m_hit[i] = 1'b1;
        m_low[i] = b;
        push_exp(i, '{addr: {m_hi[i], b}, rw: 1'b0, match: 1'b1, gc: 1'b0});
      end else begin
        m_hit[i] = 1'b0;
      end
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 3; i++) begin
        if (done[i] === 1'b1) begin
          exp_t e;
          bit   ok;
          pop_exp(i, ok, e);
          if (!ok) check("done_unexpected", i, 32'd1, 32'd0);
          else begin
            check("addr_out", i, 32'(addr_out[i]), 32'(e.addr));
            check("rd_wr", i, 32'(rd_wr[i]), 32'(e.rw));
            check("match", i, 32'(match[i]), 32'(e.match));
            check("gen_call", i, 32'(gcall[i]), 32'(e.gc));
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scl_bit(input logic v, input bit chk_ack_low);
    sda = v; tick(2);
    rise = 1'b1; tick(1); rise = 1'b0; tick(2);
    if (chk_ack_low)
      for (int i = 0; i < 3; i++) check("ack_early", i, 32'(ack[i]), 32'd0);
    fall = 1'b1; tick(1); fall = 1'b0; tick(1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit exp_ack [3];
    for (int i = 0; i < 3; i++) model_byte(i, b, exp_ack[i]);
    for (int k = 7; k >= 0; k--) scl_bit(b[k], k == 0);
    sda = 1'b1; tick(2);
    for (int i = 0; i < 3; i++) begin
      check("ack_slot", i, 32'(ack[i]), 32'(exp_ack[i]));
      check("busy_ack", i, 32'(busy[i]), 32'(exp_ack[i]));
    end
    rise = 1'b1; tick(1); rise = 1'b0; tick(2);
    for (int i = 0; i < 3; i++) check("ack_hold", i, 32'(ack[i]), 32'(exp_ack[i]));
    fall = 1'b1; tick(1); fall = 1'b0; tick(2);
    for (int i = 0; i < 3; i++) check("ack_release", i, 32'(ack[i]), 32'd0);
  endtask

  task automatic do_start();
    for (int i = 0; i < 3; i++) m_phase[i] = 1;
    start = 1'b1; tick(1); start = 1'b0; tick(2);
  endtask

  task automatic do_stop();
    for (int i = 0; i < 3; i++) begin m_phase[i] = 0; m_hit[i] = 1'b0; end
    stop = 1'b1; tick(1); stop = 1'b0; tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_addr"}, i, 32'(addr_out[i]), 32'd0);
      check({tag, "_rdwr"}, i, 32'(rd_wr[i]), 32'd0);
      check({tag, "_match"}, i, 32'(match[i]), 32'd0);
      check({tag, "_gc"}, i, 32'(gcall[i]), 32'd0);
      check({tag, "_done"}, i, 32'(done[i]), 32'd0);
      check({tag, "_ack"}, i, 32'(ack[i]), 32'd0);
      check({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
    end
  endtask

  function automatic logic [7:0] pick_b1();
    logic rw;
    rw = 1'($urandom);
    case ($urandom_range(0, 5))
      0: return {own[0][6:0], rw};
      1: return {own[2][6:0], rw};
      2: return 8'h00;
      3, 4: return {5'b11110, own[1][9:8], rw};
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick_b2();
    if ($urandom_range(0, 9) < 7) return own[1][7:0];
    return 8'($urandom);
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sda = 1'b1; rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
    own[0] = 10'h052; own[1] = 10'h2B7; own[2] = 10'h052;
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_hit[i] = 1'b0; m_low[i] = '0; m_hi[i] = '0;
    end
    tick(3);
    check_all_zero("reset");
    rst = 1'b0; tick(2);

    // 7-bit match write
    do_start(); send_byte(8'hA4); do_stop();
    for (int i = 0; i < 3; i++) check("stop_match_clr", i, 32'(match[i]), 32'd0);
    // Mismatch, then repeated START with a read
    do_start(); send_byte(8'hA6); do_start(); send_byte(8'hA5); do_stop();
    // General call
    do_start(); send_byte(8'h00); do_stop();
    // 10-bit write, read resume, resume after STOP refused
    do_start(); send_byte(8'hF4); send_byte(8'hB7);
    do_start(); send_byte(8'hF5); do_stop();
    do_start(); send_byte(8'hF5); do_stop();
    // 10-bit low-byte mismatch clears the hit flag
    do_start(); send_byte(8'hF4); send_byte(8'hB7);
    do_start(); send_byte(8'hF4); send_byte(8'hB6);
    do_start(); send_byte(8'hF5); do_stop();

    // Asynchronous reset in the middle of the first byte
    do_start();
    for (int k = 7; k >= 4; k--) scl_bit(1'b1, 1'b0);
    rst = 1'b1; #2;
    for (int i = 0; i < 3; i++) begin
      m_phase[i] = 0; m_hit[i] = 1'b0; m_low[i] = '0;
    end
    check_all_zero("midreset");
    tick(2); rst = 1'b0; tick(2);

    // STOP after 5 bits
    do_start();
    for (int k = 7; k >= 3; k--) scl_bit(1'b0, 1'b0);
    do_stop();
    for (int i = 0; i < 3; i++) begin
      check("stop5_busy", i, 32'(busy[i]), 32'd0);
      check("stop5_ack", i, 32'(ack[i]), 32'd0);
      check("stop5_match", i, 32'(match[i]), 32'd0);
    end
    do_start(); send_byte(8'hA4); do_stop();

    // Randomised traffic
    for (int n = 0; n < 70; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        own[0] = {3'b000, 7'($urandom)};
        own[1] = 10'($urandom);
        own[2] = {3'b000, 7'($urandom)};
      end
      do_start();
      send_byte(pick_b1());
      if ($urandom_range(0, 1) == 1) send_byte(pick_b2());
      if ($urandom_range(0, 1) == 1) begin
        do_start();
        send_byte(pick_b1());
      end
      do_stop();
    end

    tick(20);
    for (int i = 0; i < 3; i++) check("queue_empty", i, 32'(qsize(i)), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
